// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - transmit word stream between the register-map controller and the UART
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] s_data_i;
  logic                  s_valid_i;
  logic                  s_ready_o;

  modport master (output s_data_i, output s_valid_i, input s_ready_o);
  modport slave  (input s_data_i, input s_valid_i, output s_ready_o);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with configurable frame format and baud divisor
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                               clk_i,
  input  logic                               a_rst_i,
  uart_tx_fifo_if.slave                      s,
  input  logic                               enable_i,
  input  logic [3:0]                         data_bits_i,
  input  logic [1:0]                         parity_i,
  input  logic                               stop2_i,
  input  logic [DIV_WIDTH-1:0]               baud_div_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level_o,
  output logic                               fifo_empty_o,
  output logic                               fifo_full_o,
  output logic                               busy_o,
  output logic                               frame_done_o,
  output logic                               tx_o
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level_q, level_d;
  logic                  full_q, empty_q;
  logic                  push, pop;

  // Frame engine
  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, div_q;
  logic [3:0]            idx_q, nbits_q, n_clamp;
  logic [DATA_WIDTH-1:0] shreg_q, head, mask;
  logic                  par_en_q, par_bit_q, par_bit_d, stop2_q;
  logic                  tx_q, tx_d, done, bit_end, can_pop;

  assign push     = s.s_valid_i && !full_q;
  assign can_pop  = enable_i && !empty_q;
  assign bit_end  = (cnt_q == '0);
  assign head     = mem[rd_ptr];

  assign s.s_ready_o   = !full_q;
  assign fifo_level_o  = level_q;
  assign fifo_full_o   = full_q;
  assign fifo_empty_o  = empty_q;
  assign busy_o        = (state_q != IDLE);
  assign frame_done_o  = done;
  assign tx_o          = tx_q;

  // Clamp the requested word length and derive the parity bit of the word about to be popped
  always_comb begin
    if (data_bits_i < 4'd5)
      n_clamp = 4'd5;
    else if (data_bits_i > 4'(DATA_WIDTH))
      n_clamp = 4'(DATA_WIDTH);
    else
      n_clamp = data_bits_i;
    mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      mask[i] = (4'(i) < n_clamp);
    case (parity_i)
      2'b01:   par_bit_d = ^(head & mask);
      2'b10:   par_bit_d = ~^(head & mask);
      2'b11:   par_bit_d = 1'b1;
      default: par_bit_d = 1'b0;
    endcase
  end

  // Level arithmetic: simultaneous push and pop leaves the count unchanged
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers and registered level/flags
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == LW'(FIFO_DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  // FIFO word storage; contents need no reset
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= s.s_data_i;
  end

  // Frame state register
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state, pop decision, frame-done pulse and serial bit selection
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done    = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx_d = shreg_q[0];
        if (bit_end && idx_q == nbits_q - 4'd1)
          state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_d = par_bit_q;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end && idx_q == (stop2_q ? 4'd1 : 4'd0)) begin
          done = 1'b1;
          if (can_pop) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timer, bit index, shift register and configuration latched at pop
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) begin
      cnt_q     <= '0;
      div_q     <= '0;
      idx_q     <= '0;
      nbits_q   <= 4'd5;
      shreg_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (pop) begin
      cnt_q     <= baud_div_i;
      div_q     <= baud_div_i;
      idx_q     <= '0;
      nbits_q   <= n_clamp;
      shreg_q   <= head;
      par_en_q  <= (parity_i != 2'b00);
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_i;
    end else if (state_q != IDLE) begin
      if (bit_end) begin
        cnt_q <= div_q;
        idx_q <= (state_d != state_q) ? 4'd0 : idx_q + 4'd1;
        if (state_q == DATA) shreg_q <= shreg_q >> 1;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Registered serial output, forced idle-high by reset
  always_ff @(posedge clk_i or posedge a_rst_i) begin
    if (a_rst_i) tx_q <= 1'b1;
    else         tx_q <= tx_d;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
  logic        clk = 1'b0;
  logic        a_rst_i;
  logic        enable_i;
  logic [3:0]  data_bits_i;
  logic [1:0]  parity_i;
  logic        stop2_i;
  logic [15:0] baud_div_i;
  logic [4:0]  fifo_level_o;
  logic        fifo_empty_o, fifo_full_o, busy_o, frame_done_o, tx_o;
  int          checks = 0;
  int          errors = 0;
  int          waited;

  uart_tx_fifo_if #(.DATA_WIDTH(8)) sif ();

  uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
    .clk_i        (clk),
    .a_rst_i      (a_rst_i),
    .s            (sif.slave),
    .enable_i     (enable_i),
    .data_bits_i  (data_bits_i),
    .parity_i     (parity_i),
    .stop2_i      (stop2_i),
    .baud_div_i   (baud_div_i),
    .fifo_level_o (fifo_level_o),
    .fifo_empty_o (fifo_empty_o),
    .fifo_full_o  (fifo_full_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .tx_o         (tx_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    sif.s_data_i  = d;
    sif.s_valid_i = 1'b1;
    tick();
    sif.s_valid_i = 1'b0;
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic s2, input logic [15:0] div);
    data_bits_i = nb;
    parity_i    = par;
    stop2_i     = s2;
    baud_div_i  = div;
  endtask

  // Expected line bits (index 0 = start bit) for an 8-bit-max word
  function automatic logic [15:0] model_bits(input logic [7:0] d, input int n, input int par,
                                             input bit s2, output int len);
    logic [15:0] b;
    logic        p;
    int          k;
    b = '0;
    p = 1'b0;
    for (int i = 0; i < n; i++) begin
      b[1+i] = d[i];
      p = p ^ d[i];
    end
    k = 1 + n;
    if (par != 0) begin
      b[k] = (par == 1) ? p : (par == 2) ? ~p : 1'b1;
      k++;
    end
    b[k] = 1'b1;
    k++;
    if (s2) begin
      b[k] = 1'b1;
      k++;
    end
    len = k;
    return b;
  endfunction

  // Waits for a frame to start, then checks every line cycle, the done pulse and busy
  task automatic check_frame(input string tag, input logic [15:0] bits, input int nbf, input int div,
                             input bit more, input int drop_at, output int w);
    logic [15:0] got;
    int          glitches, done_cnt, done_at, busy_cnt, len, b;
    len = nbf * (div + 1);
    w = 0;
    while (!busy_o && w < 300) begin
      tick();
      w++;
    end
    if (!busy_o) begin
      chk({tag, "_start_timeout"}, busy_o, 1);
      return;
    end
    got = '0;
    glitches = 0;
    done_cnt = 0;
    done_at = -1;
    busy_cnt = 0;
    for (int c = 0; c <= len; c++) begin
      if (c == drop_at) enable_i = 1'b0;
      if (c < len) begin
        if (busy_o) busy_cnt++;
        if (frame_done_o) begin
          done_cnt++;
          done_at = c;
        end
      end
      if (c >= 1) begin
        b = (c - 1) / (div + 1);
        if ((c - 1) % (div + 1) == 0) got[b] = tx_o;
        if (tx_o !== bits[b]) glitches++;
      end
      if (c < len) tick();
    end
    chk({tag, "_bits"}, got, bits);
    chk({tag, "_glitches"}, glitches, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_at"}, done_at, len - 1);
    chk({tag, "_busy_cycles"}, busy_cnt, len);
    chk({tag, "_busy_after"}, busy_o, more);
  endtask

  initial begin
    logic [15:0] eb;
    int          elen, bc;

    a_rst_i       = 1'b1;
    enable_i      = 1'b0;
    sif.s_valid_i = 1'b0;
    sif.s_data_i  = '0;
    set_cfg(4'd8, 2'b00, 1'b0, 16'd3);
    tick();
    tick();
    a_rst_i = 1'b0;
    tick();

    // Reset state
    chk("rst_tx", tx_o, 1);
    chk("rst_ready", sif.s_ready_o, 1);
    chk("rst_empty", fifo_empty_o, 1);
    chk("rst_full", fifo_full_o, 0);
    chk("rst_level", fifo_level_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", frame_done_o, 0);

    // 8N1, div=3, 0xA5
    enable_i = 1'b1;
    push(8'hA5);
    check_frame("f8n1", 16'b0000001101001010, 10, 3, 1'b0, -1, waited);
    chk("f8n1_wait", waited, 1);

    // 7E2, div=0, 0x41
    set_cfg(4'd7, 2'b01, 1'b1, 16'd0);
    push(8'h41);
    check_frame("f7e2", 16'b0000011010000010, 11, 0, 1'b0, -1, waited);

    // 5-bit odd, div=1, 0xE3
    set_cfg(4'd5, 2'b10, 1'b0, 16'd1);
    push(8'hE3);
    check_frame("f5o1", 16'b0000000011000110, 8, 1, 1'b0, -1, waited);

    // FIFO fill while disabled, overflow word rejected
    enable_i = 1'b0;
    set_cfg(4'd8, 2'b00, 1'b0, 16'd0);
    for (int i = 0; i < 17; i++) begin
      sif.s_data_i  = 8'(i);
      sif.s_valid_i = 1'b1;
      if (i == 16) chk("full_ready_low", sif.s_ready_o, 0);
      tick();
    end
    sif.s_valid_i = 1'b0;
    chk("full_level", fifo_level_o, 16);
    chk("full_flag", fifo_full_o, 1);
    chk("full_empty", fifo_empty_o, 0);
    chk("full_busy", busy_o, 0);

    // Drain back-to-back
    enable_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      eb = model_bits(8'(i), 8, 0, 1'b0, elen);
      check_frame($sformatf("drain%0d", i), eb, elen, 0, (i != 15), -1, waited);
      if (i > 0) chk($sformatf("drain%0d_gap", i), waited, 0);
    end
    tick();
    chk("drain_empty", fifo_empty_o, 1);
    chk("drain_level", fifo_level_o, 0);

    // Reset during third data bit
    set_cfg(4'd8, 2'b00, 1'b0, 16'd3);
    push(8'h00);
    bc = 0;
    while (!busy_o && bc < 20) begin
      tick();
      bc++;
    end
    chk("mid_started", busy_o, 1);
    repeat (13) tick();
    chk("mid_pre_tx", tx_o, 0);
    a_rst_i = 1'b1;
    #1;
    chk("mid_rst_tx", tx_o, 1);
    chk("mid_rst_level", fifo_level_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    tick();
    a_rst_i = 1'b0;
    bc = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy_o) bc++;
    end
    chk("mid_no_restart", bc, 0);
    eb = model_bits(8'h5A, 8, 0, 1'b0, elen);
    push(8'h5A);
    check_frame("mid_after", eb, elen, 3, 1'b0, -1, waited);

    // Enable dropped during DATA with three words queued
    enable_i = 1'b0;
    set_cfg(4'd8, 2'b00, 1'b0, 16'd1);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("en_queued", fifo_level_o, 3);
    enable_i = 1'b1;
    eb = model_bits(8'h11, 8, 0, 1'b0, elen);
    check_frame("en_f1", eb, elen, 1, 1'b0, 6, waited);
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy_o) bc++;
    end
    chk("en_held_idle", bc, 0);
    chk("en_held_level", fifo_level_o, 2);
    enable_i = 1'b1;
    eb = model_bits(8'h22, 8, 0, 1'b0, elen);
    check_frame("en_f2", eb, elen, 1, 1'b1, -1, waited);
    eb = model_bits(8'h33, 8, 0, 1'b0, elen);
    check_frame("en_f3", eb, elen, 1, 1'b0, -1, waited);
    chk("en_f3_gap", waited, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
